// File: rtl/lsu_subword_if.sv
// Bus bundle for the sub-word load/store unit: CPU request/response side
// plus the word-wide data-memory port.
interface lsu_subword_if #(
  parameter int ADDR_W = 10
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic              sgn;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              misalign;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_din;
  logic              dm_we;
  logic [31:0]       dm_dout;

  // The master plays both CPU and memory, so it also supplies dm_dout.
  modport master (
    output req, wr, size, sgn, addr, wdata, dm_dout,
    input  busy, done, misalign, rdata, dm_addr, dm_din, dm_we
  );

  modport slave (
    input  req, wr, size, sgn, addr, wdata, dm_dout,
    output busy, done, misalign, rdata, dm_addr, dm_din, dm_we
  );
endinterface

// File: rtl/lsu_subword.sv
// Load/store unit that turns byte/half/word CPU accesses into word-wide
// memory reads, read-modify-writes and writes, with alignment checking.
module lsu_subword #(
  parameter int ADDR_W = 10
) (
  input  logic         clk,
  input  logic         rst,
  lsu_subword_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_wr;
  logic [1:0]        r_size;
  logic              r_sgn;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_word;
  logic [31:0]       r_rdata;
  logic              r_mis;

  logic              w_accept;
  logic              w_mis_in;
  logic [4:0]        w_lane_lsb;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_merge;

  assign w_accept   = (r_state == S_IDLE) && bus.req;
  assign w_mis_in   = (bus.size == 2'b11)
                   || (bus.size == 2'b01 && bus.addr[0])
                   || (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);
  assign w_lane_lsb = {r_addr[1:0], 3'b000};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req) begin
          if (w_mis_in)                        w_next = S_DONE;
          else if (bus.wr && bus.size == 2'b10) w_next = S_WR;
          else                                 w_next = S_RD;
        end
      end
      S_RD:    w_next = r_wr ? S_WR : S_DONE;
      S_WR:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Load path extracts from the live memory word during RD.
  always_comb begin
    w_byte = bus.dm_dout[w_lane_lsb +: 8];
    w_half = r_addr[1] ? bus.dm_dout[31:16] : bus.dm_dout[15:0];
    case (r_size)
      2'b00:   w_load = {{24{r_sgn & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_sgn & w_half[15]}}, w_half};
      default: w_load = bus.dm_dout;
    endcase
  end

  // Store path splices the new sub-word into the word captured in RD.
  always_comb begin
    w_merge = r_word;
    case (r_size)
      2'b00: w_merge[w_lane_lsb +: 8] = r_wdata[7:0];
      2'b01: begin
        if (r_addr[1]) w_merge[31:16] = r_wdata[15:0];
        else           w_merge[15:0]  = r_wdata[15:0];
      end
      default: w_merge = r_wdata;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wr    <= 1'b0;
      r_size  <= 2'b00;
      r_sgn   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_word  <= '0;
      r_rdata <= '0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_wr    <= bus.wr;
        r_size  <= bus.size;
        r_sgn   <= bus.sgn;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
        r_mis   <= w_mis_in;
      end
      if (r_state == S_RD) begin
        r_word <= bus.dm_dout;
        if (!r_wr) r_rdata <= w_load;
      end
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.misalign = (r_state == S_DONE) && r_mis;
  // Reset gates the strobe combinationally so a write in flight is dropped.
  assign bus.dm_we    = (r_state == S_WR) && !rst;
  assign bus.dm_addr  = (r_state == S_IDLE) ? '0 : {r_addr[ADDR_W-1:2], 2'b00};
  assign bus.dm_din   = w_merge;
  assign bus.rdata    = r_rdata;

endmodule
